// File: rtl/fetch_if.sv
// Fetch-controller bus bundle: redirect input, instruction-memory port and decode handshake.
// With FETCH_MISALIGN_EN defined, the bundle also carries the fetch_misalign flag.
interface fetch_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  modport master (
`ifdef FETCH_MISALIGN_EN
    output fetch_misalign,
`endif
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_pc, id_inst
  );

  modport slave (
`ifdef FETCH_MISALIGN_EN
    input  fetch_misalign,
`endif
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time, and feeds decode.
// Optional FETCH_MISALIGN_EN adds an ERR state entered on misaligned redirect targets.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic clk,
  input  logic rst,
  fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
`ifdef FETCH_MISALIGN_EN
    , ERR
`endif
  } state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [63:0] req_pc;
  logic        kill, kill_next;
  logic [63:0] skid_pc;
  logic [31:0] skid_inst;
  logic        id_valid_q;
  logic [63:0] id_pc_q;
  logic [31:0] id_inst_q;

  logic xfer;
  logic req_accept;
  logic load_rdata;
  logic load_skid;
  logic load_from_skid;
  logic redir_bad;

  assign xfer = id_valid_q & bus.id_ready;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    kill_next      = kill;
    req_accept     = 1'b0;
    load_rdata     = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    redir_bad      = 1'b0;
`ifdef FETCH_MISALIGN_EN
    redir_bad      = bus.redirect_valid & (|bus.redirect_pc[1:0]);
`endif

    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (bus.imem_gnt) begin
          req_accept = 1'b1;
          pc_next    = pc + 64'(PC_STEP);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_next = REQ;
          if (kill) begin
            kill_next = 1'b0;
          end else if (!id_valid_q || bus.id_ready) begin
            load_rdata = 1'b1;
          end else begin
            load_skid  = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          load_from_skid = 1'b1;
          state_next     = REQ;
        end
      end
`ifdef FETCH_MISALIGN_EN
      ERR: begin
        // A request outstanding when ERR was entered still returns; retire its kill here.
        if (bus.imem_rvalid && kill) kill_next = 1'b0;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Redirect overrides every other event of the same cycle.
    if (bus.redirect_valid) begin
      pc_next        = bus.redirect_pc;
      load_rdata     = 1'b0;
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
      case (state)
        REQ: begin
          if (bus.imem_gnt) begin
            state_next = WAIT;
            kill_next  = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            state_next = REQ;
            kill_next  = 1'b0;
          end else begin
            kill_next  = 1'b1;
          end
        end
        default: state_next = REQ;
      endcase
`ifdef FETCH_MISALIGN_EN
      if (redir_bad) begin
        state_next = ERR;
      end else if (state == ERR) begin
        // Keep the one-outstanding rule: wait out a still-pending killed response first.
        state_next = kill_next ? WAIT : REQ;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      pc   <= pc_next;
      kill <= kill_next;
      if (req_accept) req_pc <= pc;
      if (bus.redirect_valid) begin
        id_valid_q <= 1'b0;
      end else if (load_rdata) begin
        id_valid_q <= 1'b1;
        id_pc_q    <= req_pc;
        id_inst_q  <= bus.imem_rdata;
      end else if (load_from_skid) begin
        id_valid_q <= 1'b1;
        id_pc_q    <= skid_pc;
        id_inst_q  <= skid_inst;
      end else if (xfer) begin
        id_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: skid contents need no reset; they are only read in HOLD, which reset leaves.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_pc   <= req_pc;
      skid_inst <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = (state == REQ);
  assign bus.imem_addr = pc;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = id_inst_q;
`ifdef FETCH_MISALIGN_EN
  assign bus.fetch_misalign = (state == ERR);
`endif

endmodule
